bsg_cache_dma_arbiter: RTL and testbench

Shares one DMA channel (packet, fill-data, evict-data) among num_cache_p cache DMA engines.
- Packets are arbitrated round-robin.
- Each accepted packet's requester id is recorded in an in-order read queue or write queue.
- Read-fill beats are steered to the oldest outstanding reader; evict beats are taken from the oldest outstanding writer.
- Sits between the per-cache DMA engines and the memory-side DMA port.

---
 rtl/bsg_cache_pkg.sv | 18 +
 rtl/bsg_cache_dma_arbiter_checker.sv | 23 ++
 rtl/bsg_cache_dma_arbiter_tracker.sv | 73 +++++++
 rtl/bsg_cache_dma_arbiter.sv | 124 ++++++++++++
 tb/tb_bsg_cache_dma_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_cache_pkg.sv
// Shared helpers for the cache DMA arbiter: packet sizing, id sizing and
// round-robin index arithmetic. Packet layout is {write_not_read, mask, addr}.
package bsg_cache_pkg;

  function automatic int safe_clog2(input int x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

  function automatic int dma_pkt_width(input int addr_w, input int block_words);
    return 1 + block_words + addr_w;
  endfunction

  // Index visited `step` positions after `ptr` in an n-entry ring.
  function automatic int rr_index(input int ptr, input int step, input int n);
    return (ptr + step) % n;
  endfunction

endpackage

// File: rtl/bsg_cache_dma_arbiter_checker.sv
// Protocol checks for the cache DMA arbiter, kept apart from the datapath.
module bsg_cache_dma_arbiter_checker #(
  parameter int num_cache_p = 4
) (
  input logic                   clk_i,
  input logic                   reset_n_i,
  input logic                   fill_v_i,
  input logic                   rq_v_i,
  input logic [num_cache_p-1:0] pkt_yumi_i,
  input logic [num_cache_p-1:0] data_yumi_i
);

  // A memory fill beat with no outstanding reader has nowhere to go.
  a_fill_has_reader: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    fill_v_i |-> rq_v_i);

  a_pkt_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(pkt_yumi_i));

  a_data_yumi_onehot: assert property (@(posedge clk_i) disable iff (!reset_n_i)
    $onehot0(data_yumi_i));

endmodule

// File: rtl/bsg_cache_dma_arbiter_tracker.sv
// In-order queue of requester ids plus a beat counter; the head entry is
// retired on the last beat of its burst.
module bsg_cache_dma_arbiter_tracker
  import bsg_cache_pkg::*;
#(
  parameter int els_p       = 4,
  parameter int id_width_p  = 2,
  parameter int burst_len_p = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic                  push_i,
  input  logic [id_width_p-1:0] push_id_i,
  input  logic                  beat_i,
  output logic [id_width_p-1:0] head_o,
  output logic                  v_o,
  output logic                  full_o
);

  localparam int ptr_width_lp  = safe_clog2(els_p);
  localparam int cnt_width_lp  = $clog2(els_p + 1);
  localparam int beat_width_lp = safe_clog2(burst_len_p);

  logic [id_width_p-1:0]    mem_r [els_p];
  logic [ptr_width_lp-1:0]  rd_ptr_r;
  logic [ptr_width_lp-1:0]  wr_ptr_r;
  logic [cnt_width_lp-1:0]  count_r;
  logic [beat_width_lp-1:0] beat_r;
  logic                     last_beat_s;
  logic                     pop_s;

  function automatic logic [ptr_width_lp-1:0] next_ptr(input logic [ptr_width_lp-1:0] p);
    return (p == ptr_width_lp'(els_p - 1)) ? '0 : p + ptr_width_lp'(1);
  endfunction

  assign v_o         = (count_r != '0);
  assign full_o      = (count_r == cnt_width_lp'(els_p));
  assign head_o      = mem_r[rd_ptr_r];
  // A one-beat burst keeps beat_r at zero, so every beat is the last.
  assign last_beat_s = (beat_r == beat_width_lp'(burst_len_p - 1));
  assign pop_s       = beat_i & v_o & last_beat_s;

  // Id storage and occupancy; push and pop in one cycle leave occupancy unchanged.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < els_p; i++) mem_r[i] <= '0;
      rd_ptr_r <= '0;
      wr_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_i) begin
        mem_r[wr_ptr_r] <= push_id_i;
        wr_ptr_r        <= next_ptr(wr_ptr_r);
      end
      if (pop_s) rd_ptr_r <= next_ptr(rd_ptr_r);
      case ({push_i, pop_s})
        2'b10:   count_r <= count_r + cnt_width_lp'(1);
        2'b01:   count_r <= count_r - cnt_width_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Beat position within the head burst.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      beat_r <= '0;
    end else if (beat_i & v_o) begin
      beat_r <= last_beat_s ? '0 : beat_r + beat_width_lp'(1);
    end
  end

endmodule

// File: rtl/bsg_cache_dma_arbiter.sv
// Shares one memory-side DMA channel among num_cache_p cache DMA engines:
// round-robin packet arbitration with in-order steering of fill and evict beats.
module bsg_cache_dma_arbiter
  import bsg_cache_pkg::*;
#(
  parameter int num_cache_p           = 4,
  parameter int addr_width_p          = 32,
  parameter int data_width_p          = 32,
  parameter int block_size_in_words_p = 8,
  parameter int dma_data_width_p      = data_width_p,
  parameter int tag_els_p             = 4,
  localparam int pkt_width_lp         = dma_pkt_width(addr_width_p, block_size_in_words_p)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_cache_p*pkt_width_lp-1:0]     dma_pkt_i,
  input  logic [num_cache_p-1:0]                  dma_pkt_v_i,
  output logic [num_cache_p-1:0]                  dma_pkt_yumi_o,
  output logic [num_cache_p*dma_data_width_p-1:0] dma_data_o,
  output logic [num_cache_p-1:0]                  dma_data_v_o,
  input  logic [num_cache_p-1:0]                  dma_data_ready_i,
  input  logic [num_cache_p*dma_data_width_p-1:0] dma_data_i,
  input  logic [num_cache_p-1:0]                  dma_data_v_i,
  output logic [num_cache_p-1:0]                  dma_data_yumi_o,
  output logic [pkt_width_lp-1:0]                 dma_pkt_o,
  output logic                                    dma_pkt_v_o,
  input  logic                                    dma_pkt_yumi_i,
  input  logic [dma_data_width_p-1:0]             dma_data_mem_i,
  input  logic                                    dma_data_mem_v_i,
  output logic                                    dma_data_mem_ready_o,
  output logic [dma_data_width_p-1:0]             dma_data_mem_o,
  output logic                                    dma_data_mem_v_o,
  input  logic                                    dma_data_mem_yumi_i
);

  localparam int burst_len_lp = block_size_in_words_p * data_width_p / dma_data_width_p;
  localparam int id_width_lp  = safe_clog2(num_cache_p);

  typedef logic [id_width_lp-1:0] id_t;

  id_t                         ptr_r;
  id_t                         cand_s;
  id_t                         scan_s [num_cache_p];
  id_t                         rq_head_s;
  id_t                         wq_head_s;
  logic                        cand_found_s;
  logic                        cand_wnr_s;
  logic                        eligible_s;
  logic                        grant_s;
  logic                        rq_v_s, rq_full_s;
  logic                        wq_v_s, wq_full_s;
  logic                        fill_hs_s;
  logic                        evict_v_s;
  logic                        evict_hs_s;
  logic [pkt_width_lp-1:0]     pkt_arr_s   [num_cache_p];
  logic [dma_data_width_p-1:0] evict_arr_s [num_cache_p];

  for (genvar g = 0; g < num_cache_p; g++) begin : g_unpack
    assign pkt_arr_s[g]   = dma_pkt_i[g*pkt_width_lp +: pkt_width_lp];
    assign evict_arr_s[g] = dma_data_i[g*dma_data_width_p +: dma_data_width_p];
    assign scan_s[g]      = id_t'(rr_index(int'(ptr_r), g + 1, num_cache_p));
  end

  // First requester after the pointer; scanned backwards so the nearest wins.
  always_comb begin
    cand_s       = id_t'(0);
    cand_found_s = 1'b0;
    for (int k = num_cache_p - 1; k >= 0; k--) begin
      cand_s       = dma_pkt_v_i[scan_s[k]] ? scan_s[k] : cand_s;
      cand_found_s = cand_found_s | dma_pkt_v_i[scan_s[k]];
    end
  end

  // An ineligible candidate blocks the channel rather than being skipped.
  assign cand_wnr_s     = pkt_arr_s[cand_s][pkt_width_lp-1];
  assign eligible_s     = cand_wnr_s ? ~wq_full_s : ~rq_full_s;
  assign dma_pkt_v_o    = reset_n_i & cand_found_s & eligible_s;
  assign dma_pkt_o      = pkt_arr_s[cand_s];
  assign grant_s        = dma_pkt_v_o & dma_pkt_yumi_i;
  assign dma_pkt_yumi_o = grant_s ? (num_cache_p'(1) << cand_s) : '0;

  assign dma_data_o           = {num_cache_p{dma_data_mem_i}};
  assign dma_data_v_o         = (rq_v_s & dma_data_mem_v_i) ? (num_cache_p'(1) << rq_head_s) : '0;
  assign dma_data_mem_ready_o = rq_v_s & dma_data_ready_i[rq_head_s];
  assign fill_hs_s            = dma_data_mem_v_i & dma_data_mem_ready_o;

  assign evict_v_s        = wq_v_s & dma_data_v_i[wq_head_s];
  assign dma_data_mem_v_o = evict_v_s;
  assign dma_data_mem_o   = evict_arr_s[wq_head_s];
  assign evict_hs_s       = evict_v_s & dma_data_mem_yumi_i;
  assign dma_data_yumi_o  = evict_hs_s ? (num_cache_p'(1) << wq_head_s) : '0;

  // Round-robin pointer follows the most recent grant.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_r <= id_t'(num_cache_p - 1);
    end else if (grant_s) begin
      ptr_r <= cand_s;
    end
  end

  bsg_cache_dma_arbiter_tracker #(
    .els_p(tag_els_p), .id_width_p(id_width_lp), .burst_len_p(burst_len_lp)
  ) read_tracker (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .push_i(grant_s & ~cand_wnr_s), .push_id_i(cand_s), .beat_i(fill_hs_s),
    .head_o(rq_head_s), .v_o(rq_v_s), .full_o(rq_full_s)
  );

  bsg_cache_dma_arbiter_tracker #(
    .els_p(tag_els_p), .id_width_p(id_width_lp), .burst_len_p(burst_len_lp)
  ) write_tracker (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .push_i(grant_s & cand_wnr_s), .push_id_i(cand_s), .beat_i(evict_hs_s),
    .head_o(wq_head_s), .v_o(wq_v_s), .full_o(wq_full_s)
  );

  bsg_cache_dma_arbiter_checker #(.num_cache_p(num_cache_p)) checker_inst (
    .clk_i(clk_i), .reset_n_i(reset_n_i),
    .fill_v_i(dma_data_mem_v_i), .rq_v_i(rq_v_s),
    .pkt_yumi_i(dma_pkt_yumi_o), .data_yumi_i(dma_data_yumi_o)
  );

endmodule

// File: tb/tb_bsg_cache_dma_arbiter.sv
// Randomized bench for bsg_cache_dma_arbiter: a queue-based model of the
// arbitration order and outstanding bursts scores every output each cycle.
module tb_bsg_cache_dma_arbiter;

  localparam int N   = 4;
  localparam int PW  = 1 + 8 + 32;
  localparam int DW  = 32;
  localparam int BL  = 8;
  localparam int TAG = 4;

  typedef struct {
    int          id;
    logic [31:0] base;
  } wr_t;

  logic            clk;
  logic            reset_n_i;
  logic [N*PW-1:0] dma_pkt_i;
  logic [N-1:0]    dma_pkt_v_i;
  logic [N-1:0]    dma_pkt_yumi_o;
  logic [N*DW-1:0] dma_data_o;
  logic [N-1:0]    dma_data_v_o;
  logic [N-1:0]    dma_data_ready_i;
  logic [N*DW-1:0] dma_data_i;
  logic [N-1:0]    dma_data_v_i;
  logic [N-1:0]    dma_data_yumi_o;
  logic [PW-1:0]   dma_pkt_o;
  logic            dma_pkt_v_o;
  logic            dma_pkt_yumi_i;
  logic [DW-1:0]   dma_data_mem_i;
  logic            dma_data_mem_v_i;
  logic            dma_data_mem_ready_o;
  logic [DW-1:0]   dma_data_mem_o;
  logic            dma_data_mem_v_o;
  logic            dma_data_mem_yumi_i;

  bsg_cache_dma_arbiter #(
    .num_cache_p(N), .addr_width_p(32), .data_width_p(DW),
    .block_size_in_words_p(8), .dma_data_width_p(DW), .tag_els_p(TAG)
  ) dut (
    .clk_i(clk), .reset_n_i(reset_n_i),
    .dma_pkt_i(dma_pkt_i), .dma_pkt_v_i(dma_pkt_v_i), .dma_pkt_yumi_o(dma_pkt_yumi_o),
    .dma_data_o(dma_data_o), .dma_data_v_o(dma_data_v_o), .dma_data_ready_i(dma_data_ready_i),
    .dma_data_i(dma_data_i), .dma_data_v_i(dma_data_v_i), .dma_data_yumi_o(dma_data_yumi_o),
    .dma_pkt_o(dma_pkt_o), .dma_pkt_v_o(dma_pkt_v_o), .dma_pkt_yumi_i(dma_pkt_yumi_i),
    .dma_data_mem_i(dma_data_mem_i), .dma_data_mem_v_i(dma_data_mem_v_i),
    .dma_data_mem_ready_o(dma_data_mem_ready_o),
    .dma_data_mem_o(dma_data_mem_o), .dma_data_mem_v_o(dma_data_mem_v_o),
    .dma_data_mem_yumi_i(dma_data_mem_yumi_i)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: arbitration pointer, outstanding ids, beat positions.
  int          m_ptr = N - 1;
  int          rd_q[$];
  wr_t         wr_q[$];
  int          rbeat = 0;
  int          wbeat = 0;
  int          grant_log[$];

  // Cache-side state: offered packet, pending evict bursts.
  logic [PW-1:0] pkt_in [N];
  bit            offering [N];
  logic [31:0]   cur_base [N];
  logic [31:0]   cache_wr_q [N][$];
  int            cache_beat [N];
  int            seq = 0;

  bit gen_en = 0;
  int p_new = 30, p_yumi = 70, p_memv = 70, p_ready = 80, p_evv = 70, p_memyumi = 70;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_model();
    m_ptr = N - 1;
    rd_q.delete();
    wr_q.delete();
    rbeat = 0;
    wbeat = 0;
    for (int i = 0; i < N; i++) begin
      offering[i] = 1'b0;
      cache_wr_q[i].delete();
      cache_beat[i] = 0;
    end
  endtask

  task automatic monitor_step();
    bit            found;
    int            cand;
    bit            cwnr, exp_pv, rv, wv, exp_rdy, exp_mv, fill_hs, ev_hs;
    int            rh, wh;
    logic [N-1:0]  exp_vec;
    if (!reset_n_i) begin
      chk("reset_outputs", {dma_pkt_v_o, dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o,
                            dma_data_mem_ready_o, dma_data_mem_v_o}, '0);
      clear_model();
      return;
    end
    found = 0; cand = 0;
    for (int k = 1; k <= N; k++) begin
      if (!found && dma_pkt_v_i[(m_ptr + k) % N]) begin
        found = 1;
        cand  = (m_ptr + k) % N;
      end
    end
    cwnr   = pkt_in[cand][PW-1];
    exp_pv = found && (cwnr ? (wr_q.size() < TAG) : (rd_q.size() < TAG));
    chk("pkt_v", dma_pkt_v_o, exp_pv);
    if (exp_pv) chk("pkt_data", dma_pkt_o, pkt_in[cand]);
    exp_vec = '0;
    if (exp_pv && dma_pkt_yumi_i) exp_vec[cand] = 1'b1;
    chk("pkt_yumi", dma_pkt_yumi_o, exp_vec);

    rv = rd_q.size() > 0;
    rh = rv ? rd_q[0] : 0;
    exp_vec = '0;
    if (rv && dma_data_mem_v_i) exp_vec[rh] = 1'b1;
    chk("fill_v", dma_data_v_o, exp_vec);
    exp_rdy = rv && dma_data_ready_i[rh];
    chk("fill_ready", dma_data_mem_ready_o, exp_rdy);
    if (rv && dma_data_mem_v_i) chk("fill_data", dma_data_o, {N{dma_data_mem_i}});
    fill_hs = dma_data_mem_v_i && exp_rdy;

    wv = wr_q.size() > 0;
    wh = wv ? wr_q[0].id : 0;
    exp_mv = wv && dma_data_v_i[wh];
    chk("evict_v", dma_data_mem_v_o, exp_mv);
    if (exp_mv) chk("evict_data", dma_data_mem_o, wr_q[0].base + 32'(wbeat));
    ev_hs = exp_mv && dma_data_mem_yumi_i;
    exp_vec = '0;
    if (ev_hs) exp_vec[wh] = 1'b1;
    chk("evict_yumi", dma_data_yumi_o, exp_vec);

    if (exp_pv && dma_pkt_yumi_i) begin
      m_ptr = cand;
      grant_log.push_back(cand);
      if (cwnr) wr_q.push_back('{cand, cur_base[cand]});
      else      rd_q.push_back(cand);
      offering[cand] = 1'b0;
    end
    if (fill_hs) begin
      rbeat++;
      if (rbeat == BL) begin rbeat = 0; void'(rd_q.pop_front()); end
    end
    if (ev_hs) begin
      wbeat++;
      cache_beat[wh]++;
      if (wbeat == BL) begin
        wbeat = 0;
        void'(wr_q.pop_front());
        void'(cache_wr_q[wh].pop_front());
        cache_beat[wh] = 0;
      end
    end
  endtask

  always @(negedge clk) monitor_step();

  task automatic offer(input int i, input bit wnr);
    logic [31:0] addr;
    logic [31:0] base;
    addr = {8'(i), 24'($urandom)};
    pkt_in[i]   = {wnr, (wnr ? 8'hFF : 8'h00), addr};
    offering[i] = 1'b1;
    if (wnr) begin
      base = (32'(i) << 24) | (32'(seq) << 4);
      seq++;
      cache_wr_q[i].push_back(base);
      cur_base[i] = base;
    end
  endtask

  task automatic zero_inputs();
    dma_pkt_i = '0; dma_pkt_v_i = '0; dma_data_ready_i = '0; dma_data_i = '0;
    dma_data_v_i = '0; dma_pkt_yumi_i = 1'b0; dma_data_mem_i = '0;
    dma_data_mem_v_i = 1'b0; dma_data_mem_yumi_i = 1'b0;
  endtask

  task automatic drive_cycle();
    for (int i = 0; i < N; i++) begin
      if (gen_en && !offering[i] && $urandom_range(99) < p_new) offer(i, 1'($urandom));
      dma_pkt_v_i[i]          = offering[i];
      dma_pkt_i[i*PW +: PW]   = pkt_in[i];
      dma_data_ready_i[i]     = $urandom_range(99) < p_ready;
      if (cache_wr_q[i].size() > 0) begin
        dma_data_v_i[i]       = $urandom_range(99) < p_evv;
        dma_data_i[i*DW +: DW] = cache_wr_q[i][0] + 32'(cache_beat[i]);
      end else begin
        dma_data_v_i[i]       = 1'b0;
        dma_data_i[i*DW +: DW] = '0;
      end
    end
    dma_pkt_yumi_i   = $urandom_range(99) < p_yumi;
    dma_data_mem_v_i = (rd_q.size() > 0) && ($urandom_range(99) < p_memv);
    dma_data_mem_i   = $urandom;
    #1;
    dma_data_mem_yumi_i = dma_data_mem_v_o && ($urandom_range(99) < p_memyumi);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive_cycle();
  endtask

  initial begin
    int gl;
    int pv[4];
    for (int i = 0; i < N; i++) begin
      pkt_in[i] = '0; offering[i] = 1'b0; cur_base[i] = '0; cache_beat[i] = 0;
    end
    zero_inputs();
    reset_n_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n_i = 1'b1;

    // All four caches read at once with yumi held: grants 0,1,2,3 in turn.
    for (int i = 0; i < N; i++) offer(i, 1'b0);
    p_yumi = 100; p_memv = 0;
    repeat (6) step();
    chk("rr_grant_count", 32'(grant_log.size()), 32'd4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) chk("rr_grant_order", 32'(grant_log[i]), 32'(i));
    p_memv = 100; p_ready = 100;
    for (int t = 0; t < 200 && rd_q.size() > 0; t++) step();
    chk("phase_a_drained", 32'(rd_q.size()), 32'd0);

    // Random traffic with varying memory fill pressure, including full queues.
    gen_en = 1; p_yumi = 70; p_ready = 80;
    pv = '{70, 5, 90, 40};
    for (int ph = 0; ph < 4; ph++) begin
      p_memv = pv[ph];
      repeat (400) step();
    end

    // Reset in the middle of a fill burst.
    p_memv = 80;
    begin
      int t;
      for (t = 0; t < 800 && !(rd_q.size() > 0 && rbeat == 3); t++) step();
      chk("reach_beat3", 1'(rd_q.size() > 0 && rbeat == 3), 1'b1);
    end
    @(posedge clk);
    #1;
    gen_en = 0;
    zero_inputs();
    reset_n_i = 1'b0;
    #1;
    chk("async_reset_outputs", {dma_pkt_v_o, dma_pkt_yumi_o, dma_data_v_o, dma_data_yumi_o,
                                dma_data_mem_ready_o, dma_data_mem_v_o}, '0);
    repeat (2) @(posedge clk);
    #1;
    reset_n_i = 1'b1;
    gl = grant_log.size();
    for (int i = N - 1; i >= 0; i--) offer(i, 1'($urandom));
    p_yumi = 100;
    step();
    for (int t = 0; t < 20 && grant_log.size() <= gl; t++) step();
    if (grant_log.size() > gl) chk("first_grant_after_reset", 32'(grant_log[gl]), 32'd0);
    else chk("first_grant_after_reset_timeout", 1'b0, 1'b1);

    gen_en = 1; p_yumi = 60; p_memv = 60;
    repeat (500) step();

    // Drain everything outstanding.
    gen_en = 0;
    p_yumi = 100; p_memv = 100; p_ready = 100; p_evv = 100; p_memyumi = 100;
    begin
      int t;
      for (t = 0; t < 2000; t++) begin
        if (rd_q.size() == 0 && wr_q.size() == 0 && !offering[0] && !offering[1] &&
            !offering[2] && !offering[3]) break;
        step();
      end
      chk("drain_complete", 32'(rd_q.size() + wr_q.size()), 32'd0);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
